// File: rtl/read_seq_fsm_pkg.sv
// Shared types and constants for the read-sequence display FSM.
package read_pkg;

  localparam int unsigned CODE_WIDTH  = 4;
  localparam int unsigned IDX_WIDTH   = 4;
  localparam int unsigned MAX_MSG_LEN = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Message character codes, played from index 0 upward; only the first MSG_LEN are used.
  localparam logic [CODE_WIDTH-1:0] MSG_CODE [MAX_MSG_LEN] = '{
    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
    4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0
  };

endpackage

// File: rtl/read_seq_fsm_if.sv
// Control/display bundle between the sequencer and its host / 7-segment decoder.
interface read_seq_fsm_if;

  logic                           start;
  logic                           pause;
  logic [read_pkg::CODE_WIDTH-1:0] code_out;
  logic                           blank;
  logic                           busy;
  logic                           done;

  modport master (
    output start, pause,
    input  code_out, blank, busy, done
  );

  modport slave (
    input  start, pause,
    output code_out, blank, busy, done
  );

endinterface

// File: rtl/read_seq_fsm_msg_rom.sv
// Combinational message ROM: character index to 4-bit display code.
module msg_rom
  import read_pkg::*;
#(
  parameter int unsigned MSG_LEN = 8
) (
  input  logic [IDX_WIDTH-1:0]  idx_i,
  output logic [CODE_WIDTH-1:0] code_c_o
);

  // Entries past the message length read as zero.
  always_comb begin
    code_c_o = '0;
    if (32'(idx_i) < MSG_LEN) begin
      code_c_o = MSG_CODE[idx_i];
    end
  end

endmodule

// File: rtl/read_seq_fsm.sv
// Read-sequence FSM: shows MSG_LEN characters for DWELL cycles each, blanked
// for GAP cycles between them. Define READ_SEQ_LOOP_EN to repeat the message
// forever instead of stopping in DONE.
module read_seq_fsm
  import read_pkg::*;
#(
  parameter int unsigned MSG_LEN = 8,
  parameter int unsigned DWELL   = 50000000,
  parameter int unsigned GAP     = 5000000
) (
  input  logic          clk,
  input  logic          reset,
  read_seq_fsm_if.slave bus
);

  localparam int unsigned CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]     DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]     GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST   = IDX_WIDTH'(MSG_LEN - 1);

  state_e                state_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  start_q;
  logic                  armed_q;
  logic [CODE_WIDTH-1:0] code_q;
  logic                  blank_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  start_edge_c;
  logic [IDX_WIDTH-1:0]  rom_addr_c;
  logic [CODE_WIDTH-1:0] rom_code_c;

  // Start edge detect; armed_q requires start to be seen low after reset so a
  // level held high across reset release is not taken as an edge.
  // ROM address is the index of the character about to be loaded.
  always_comb begin
    start_edge_c = bus.start & ~start_q & armed_q;
    rom_addr_c   = (start_edge_c || (idx_q == IDX_LAST)) ? '0 : idx_q + IDX_WIDTH'(1);
  end

  msg_rom #(
    .MSG_LEN (MSG_LEN)
  ) u_msg_rom (
    .idx_i    (rom_addr_c),
    .code_c_o (rom_code_c)
  );

  // Sequencer state, counters and registered display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      armed_q <= 1'b0;
      code_q  <= '0;
      blank_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= bus.start;
      armed_q <= armed_q | ~bus.start;

      if (start_edge_c) begin
        state_q <= ST_SHOW;
        idx_q   <= '0;
        cnt_q   <= '0;
        code_q  <= rom_code_c;
        blank_q <= 1'b0;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_SHOW: begin
            if (!bus.pause) begin
              if (cnt_q == DWELL_LAST) begin
                state_q <= ST_GAP;
                cnt_q   <= '0;
                blank_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          ST_GAP: begin
            if (!bus.pause) begin
              if (cnt_q == GAP_LAST) begin
                cnt_q <= '0;
                if (idx_q != IDX_LAST) begin
                  state_q <= ST_SHOW;
                  idx_q   <= idx_q + IDX_WIDTH'(1);
                  code_q  <= rom_code_c;
                  blank_q <= 1'b0;
                end else begin
`ifdef READ_SEQ_LOOP_EN
                  state_q <= ST_SHOW;
                  idx_q   <= '0;
                  code_q  <= rom_code_c;
                  blank_q <= 1'b0;
`else
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
`endif
                end
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          default: begin
            // IDLE and DONE only leave on a start edge.
          end
        endcase
      end
    end
  end

  assign bus.code_out = code_q;
  assign bus.blank    = blank_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_read_seq_fsm.sv
// Bench for read_seq_fsm: timeline model (position since start edge) checked
// every cycle, plus directed literal expectations.
module tb_read_seq_fsm;

  localparam int unsigned MSG_LEN = 3;
  localparam int unsigned DWELL   = 4;
  localparam int unsigned GAP     = 2;
  localparam int unsigned PER     = DWELL + GAP;
  localparam int unsigned TOTAL   = MSG_LEN * PER;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  read_seq_fsm_if bus ();

  read_seq_fsm #(
    .MSG_LEN (MSG_LEN),
    .DWELL   (DWELL),
    .GAP     (GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit checking = 1'b0;

  // Model: mode 0 = idle after reset, 1 = playing, 2 = finished.
  // m_p counts unpaused cycles since the start edge.
  int m_mode = 0;
  int m_p    = 0;
  bit m_prev = 1'b1;
  bit m_edge;

  task automatic cmp(input string nm, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  function automatic int exp_code();
    if (m_mode == 1) return (m_p / PER) + 1;
    if (m_mode == 2) return MSG_LEN;
    return 0;
  endfunction

  function automatic int exp_blank();
    if (m_mode == 1) return ((m_p % PER) >= DWELL) ? 1 : 0;
    return 1;
  endfunction

  // Reference model update.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0;
      m_p    = 0;
      m_prev = 1'b1;
    end else begin
      m_edge = bus.start && !m_prev;
      m_prev = bus.start;
      if (m_edge) begin
        m_mode = 1;
        m_p    = 0;
      end else if (m_mode == 1 && !bus.pause) begin
        m_p++;
        if (m_p == TOTAL) begin
`ifdef READ_SEQ_LOOP_EN
          m_p = 0;
`else
          m_mode = 2;
`endif
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      cmp("code_out", int'(bus.code_out), exp_code());
      cmp("blank",    int'(bus.blank),    exp_blank());
      cmp("busy",     int'(bus.busy),     (m_mode == 1) ? 1 : 0);
      cmp("done",     int'(bus.done),     (m_mode == 2) ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;
    #1 reset = 1'b1;
    checking = 1'b1;

    // Reset state.
    cyc(3);
    cmp("rst_code", int'(bus.code_out), 0);
    cmp("rst_blank", int'(bus.blank), 1);
    cmp("rst_busy", int'(bus.busy), 0);
    cmp("rst_done", int'(bus.done), 0);
    reset = 1'b0;

    // Full playback with start held high.
    cyc(1);
    bus.start = 1'b1;
    cyc(1);
    cmp("c1_code", int'(bus.code_out), 1);
    cmp("c1_blank", int'(bus.blank), 0);
    cmp("c1_busy", int'(bus.busy), 1);
    cyc(3);
    cmp("c1_last_blank", int'(bus.blank), 0);
    cyc(1);
    cmp("gap1_blank", int'(bus.blank), 1);
    cmp("gap1_code", int'(bus.code_out), 1);
    cyc(2);
    cmp("c2_code", int'(bus.code_out), 2);
    cmp("c2_blank", int'(bus.blank), 0);
    cyc(6);
    cmp("c3_code", int'(bus.code_out), 3);
    cyc(6);
`ifdef READ_SEQ_LOOP_EN
    cmp("loop_code", int'(bus.code_out), 1);
    cmp("loop_blank", int'(bus.blank), 0);
    cmp("loop_done", int'(bus.done), 0);
`else
    cmp("end_done", int'(bus.done), 1);
    cmp("end_busy", int'(bus.busy), 0);
    cmp("end_blank", int'(bus.blank), 1);
    cyc(20);
    cmp("held_done", int'(bus.done), 1);
    cmp("held_busy", int'(bus.busy), 0);
`endif

    // Pause during second character stretches it to 9 cycles.
    bus.start = 1'b0;
    cyc(1);
    bus.start = 1'b1;
    cyc(1);
    cmp("p_c1_code", int'(bus.code_out), 1);
    bus.start = 1'b0;
    cyc(6);
    cmp("p_c2_code", int'(bus.code_out), 2);
    cyc(1);
    bus.pause = 1'b1;
    cyc(5);
    bus.pause = 1'b0;
    cyc(2);
    cmp("p_c2_end_code", int'(bus.code_out), 2);
    cmp("p_c2_end_blank", int'(bus.blank), 0);
    cyc(1);
    cmp("p_gap_blank", int'(bus.blank), 1);

    // Restart during the gap after character 2.
    bus.start = 1'b1;
    cyc(1);
    cmp("rs_code", int'(bus.code_out), 1);
    cmp("rs_blank", int'(bus.blank), 0);
    cmp("rs_busy", int'(bus.busy), 1);

    // Reset during character 3, start held high through release.
    cyc(13);
    cmp("pre_rst_code", int'(bus.code_out), 3);
    reset = 1'b1;
    #1;
    cmp("arst_code", int'(bus.code_out), 0);
    cmp("arst_blank", int'(bus.blank), 1);
    cmp("arst_busy", int'(bus.busy), 0);
    cyc(1);
    reset = 1'b0;
    cyc(5);
    cmp("post_rst_busy", int'(bus.busy), 0);
    cmp("post_rst_blank", int'(bus.blank), 1);
    cmp("post_rst_done", int'(bus.done), 0);

    // Randomized stimulus checked by the per-cycle model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.start = ~bus.start;
      bus.pause = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
